// File: rtl/width_down_conv.sv
`default_nettype none
// ============================================================================
// Module   : width_down_conv
// Purpose  : IN_W -> OUT_W width down-converter with valid/ready on both
//            sides and a one-word holding buffer for bubble-free streaming.
//            Optional out_last port enabled by defining WDC_LAST_EN.
// Revision : 1.0  initial release
// ============================================================================
module width_down_conv #(
   parameter int IN_W      = 32,
   parameter int OUT_W     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
`ifdef WDC_LAST_EN
   output logic             out_last,
`endif
   input  logic             out_ready
);

   localparam int RATIO = IN_W / OUT_W;
   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_param_check
      $error("width_down_conv: IN_W must be a multiple of OUT_W with RATIO >= 2");
   end

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t            state, state_n;
   logic [IN_W-1:0]   sh, sh_n, sh_shifted;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [IN_W-1:0]   hold, hold_n;
   logic              hold_full, hold_full_n;

   logic              slice_acc;
   logic              in_acc;
   logic              last;
   logic              sh_avail;

   assign out_valid = (state == SHIFT);
   assign last      = (idx == LAST_IDX);
   assign slice_acc = out_valid && out_ready;
   assign in_acc    = in_valid && in_ready;
   // sh can take a new word if it is empty or its final slice leaves now
   assign sh_avail  = (state == EMPTY) || (slice_acc && last);

   if (MSB_FIRST) begin : g_msb_first
      assign out_data   = sh[IN_W-1 -: OUT_W];
      assign sh_shifted = sh << OUT_W;
   end else begin : g_lsb_first
      assign out_data   = sh[OUT_W-1:0];
      assign sh_shifted = sh >> OUT_W;
   end

`ifdef WDC_LAST_EN
   assign out_last = out_valid && last;
`else
   // out_last is not present in this build
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         sh        <= '0;
         idx       <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         state     <= state_n;
         sh        <= sh_n;
         idx       <= idx_n;
         hold      <= hold_n;
         hold_full <= hold_full_n;
         in_ready  <= !hold_full_n;
      end
   end

   always_comb begin
      state_n     = state;
      sh_n        = sh;
      idx_n       = idx;
      hold_n      = hold;
      hold_full_n = hold_full;

      if (slice_acc) begin
         if (!last) begin
            sh_n  = sh_shifted;
            idx_n = idx + IDX_W'(1);
         end else begin
            idx_n = '0;
            if (hold_full) begin
               sh_n        = hold;
               hold_full_n = 1'b0;
            end else begin
               state_n = EMPTY;
            end
         end
      end

      // Input block runs after the slice block so a reload from hold and a
      // new write into hold can coexist in the same cycle.
      if (in_acc) begin
         if (sh_avail && !hold_full) begin
            sh_n    = in_data;
            state_n = SHIFT;
         end else begin
            hold_n      = in_data;
            hold_full_n = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_width_down_conv.sv
`default_nettype none
// Testbench for width_down_conv: MSB-first and LSB-first instances share the
// same stimulus; a queue per instance holds the expected slices.
module tb_width_down_conv;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        in_ready_m, out_valid_m;
   logic [7:0]  out_data_m;
   logic        in_ready_l, out_valid_l;
   logic [7:0]  out_data_l;
`ifdef WDC_LAST_EN
   logic        out_last_m, out_last_l;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pops_m = 0;
   int first_pop = -1;
   int last_pop  = -1;
   logic acc;
   logic [8:0] q_m[$];
   logic [8:0] q_l[$];

   always #5 clk = ~clk;

   width_down_conv #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_m), .out_valid(out_valid_m), .out_data(out_data_m),
`ifdef WDC_LAST_EN
      .out_last(out_last_m),
`endif
      .out_ready(out_ready)
   );

   width_down_conv #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_l), .out_valid(out_valid_l), .out_data(out_data_l),
`ifdef WDC_LAST_EN
      .out_last(out_last_l),
`endif
      .out_ready(out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: scoreboard work at negedge, return 1ns after the posedge.
   task automatic tick();
      logic [8:0] e;
      @(negedge clk);
      acc = 1'b0;
      if (!reset) begin
         if (out_valid_m && out_ready) begin
            if (q_m.size() == 0) chk("msb_unexpected_slice", {24'd0, out_data_m}, 32'hxxxx_xxxx);
            else begin
               e = q_m.pop_front();
               chk("msb_slice", {24'd0, out_data_m}, {24'd0, e[7:0]});
`ifdef WDC_LAST_EN
               chk("msb_last", {31'd0, out_last_m}, {31'd0, e[8]});
`endif
               if (first_pop < 0) first_pop = cyc;
               last_pop = cyc;
               pops_m++;
            end
         end
         if (out_valid_l && out_ready) begin
            if (q_l.size() == 0) chk("lsb_unexpected_slice", {24'd0, out_data_l}, 32'hxxxx_xxxx);
            else begin
               e = q_l.pop_front();
               chk("lsb_slice", {24'd0, out_data_l}, {24'd0, e[7:0]});
`ifdef WDC_LAST_EN
               chk("lsb_last", {31'd0, out_last_l}, {31'd0, e[8]});
`endif
            end
         end
         if (in_valid && in_ready_m) begin
            acc = 1'b1;
            for (int i = 0; i < 4; i++) begin
               q_m.push_back({i == 3, in_data[31-8*i -: 8]});
               q_l.push_back({i == 3, in_data[8*i +: 8]});
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input logic [31:0] w);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = w;
      acc      = 1'b0;
      while (!acc && n < 20) begin
         tick();
         n++;
      end
      chk("send_accepted", {31'd0, acc}, 32'd1);
      in_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] words[3];
      int widx;
      logic saw_low;

      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      @(posedge clk); #1;
      tick();
      chk("rst_out_valid", {31'd0, out_valid_m}, 32'd0);
      chk("rst_out_data",  {24'd0, out_data_m},  32'd0);
      chk("rst_in_ready",  {31'd0, in_ready_m},  32'd0);
      reset = 1'b0;
      chk("in_ready_before_edge", {31'd0, in_ready_m}, 32'd0);
      tick();
      chk("in_ready_after_release", {31'd0, in_ready_m}, 32'd1);

      // Single word, one-cycle latency, four slices then idle
      send(32'hDDCCBBAA);
      chk("latency_valid", {31'd0, out_valid_m}, 32'd1);
      chk("first_slice_msb", {24'd0, out_data_m}, 32'hDD);
      chk("first_slice_lsb", {24'd0, out_data_l}, 32'hAA);
      repeat (4) tick();
      chk("idle_after_word", {31'd0, out_valid_m}, 32'd0);
      chk("queue_drained_single", q_m.size(), 0);

      // Back-to-back words with in_valid held
      words[0] = 32'hFFFFFFFF; words[1] = 32'hDDDDDDDD; words[2] = 32'h00000003;
      widx = 0; saw_low = 1'b0; pops_m = 0; first_pop = -1; last_pop = -1;
      for (int k = 0; k < 16; k++) begin
         in_valid = (widx < 3);
         in_data  = (widx < 3) ? words[widx] : 32'h0;
         tick();
         if (acc) widx++;
         if (!in_ready_m) saw_low = 1'b1;
      end
      in_valid = 1'b0;
      chk("b2b_words_accepted", widx, 3);
      chk("b2b_slice_count", pops_m, 12);
      chk("b2b_no_gaps", last_pop - first_pop, 11);
      chk("b2b_in_ready_drop", {31'd0, saw_low}, 32'd1);
      chk("b2b_idle", {31'd0, out_valid_m}, 32'd0);

      // Downstream stall on second slice
      send(32'h11223344);
      tick();
      out_ready = 1'b0;
      repeat (3) begin
         tick();
         chk("stall_valid", {31'd0, out_valid_m}, 32'd1);
         chk("stall_data_msb", {24'd0, out_data_m}, 32'h22);
         chk("stall_data_lsb", {24'd0, out_data_l}, 32'h33);
      end
      out_ready = 1'b1;
      repeat (4) tick();
      chk("stall_drained", q_m.size(), 0);
      chk("stall_idle", {31'd0, out_valid_m}, 32'd0);

      // Reset mid-word with a second word held
      send(32'hAABBCCDD);
      in_valid = 1'b1; in_data = 32'h55667788;
      tick();
      chk("second_word_held", {31'd0, acc}, 32'd1);
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      q_m.delete(); q_l.delete();
      chk("midrst_out_valid", {31'd0, out_valid_m}, 32'd0);
      chk("midrst_out_data",  {24'd0, out_data_m},  32'd0);
      chk("midrst_in_ready",  {31'd0, in_ready_m},  32'd0);
      repeat (6) begin
         tick();
         chk("no_stale_slices", {31'd0, out_valid_m | out_valid_l}, 32'd0);
      end
      chk("ready_after_midrst", {31'd0, in_ready_m}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/width_down_conv.md
# width_down_conv

Parametrised, single-clock width down-converter: accepts IN_W-bit words with a valid/ready handshake and emits them as RATIO = IN_W/OUT_W consecutive OUT_W-bit slices with valid/ready backpressure. It generalises the fixed 32→8 converter: arbitrary integer ratio, a selectable slice order, downstream backpressure, and a one-word holding buffer so input and output stream without bubbles. It sits between a wide datapath stage and a narrow serial or lane stage.

## Interface
- IN_W, 32, input word width
- OUT_W, 8, output slice width; IN_W % OUT_W == 0 and RATIO ≥ 2, otherwise elaboration error
- MSB_FIRST, 1, 1: most-significant slice first; 0: least-significant slice first
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input word present
- in_data  in  IN_W  input word
- in_ready  out  1  registered; converter accepts a word when in_valid && in_ready
- out_valid  out  1  output slice present
- out_data  out  OUT_W  current slice
- out_ready  in  1  downstream accepts the slice when out_valid && out_ready
- out_last  out  1  present only with WDC_LAST_EN

## Operation
- Storage: shift register `sh` (IN_W) with `sh_valid`; slice index `idx` (clog2(RATIO) bits); holding register `hold` with `hold_full`.
- States: EMPTY (!sh_valid), SHIFT (sh_valid, idx 0..RATIO-1).
- out_valid = sh_valid. out_data = top slice of `sh` (MSB_FIRST=1) or bottom slice (MSB_FIRST=0); `sh` shifts by OUT_W toward the emitted end on each accepted slice.
- Slice accept with idx < RATIO-1: idx+1, shift. With idx == RATIO-1: idx←0; reload from `hold` if hold_full (hold empties); else from in_data if an input is accepted this cycle; else sh_valid←0.
- Input accept: the word goes directly to `sh` if `sh` is empty or being freed this cycle and `hold` is empty; otherwise it goes to `hold`. The hold-to-sh reload and a new input write to `hold` may occur in the same cycle.
- in_ready is registered: next value = !hold_full_next. Words are never dropped or duplicated.
- out_valid && !out_ready: out_data, idx and `sh` hold stable.

## Timing
- Reset values: out_valid=0, out_data=0, in_ready=0, out_last=0, idx=0, hold_full=0. in_ready rises on the first edge after reset deasserts.
- Latency: word accepted at edge N into EMPTY → first slice valid in cycle N+1.
- Throughput: with out_ready=1, one slice per cycle; back-to-back words give no bubble between the last slice of a word and the first slice of the next.
- Reset asserted mid-word: on the next edge all state clears and the remaining slices and the held word are discarded.

## Configuration
- WDC_LAST_EN defined: out_last port exists; out_last = out_valid && idx == RATIO-1, combinational from state.
- Undefined: port and logic are absent; all other behaviour is identical.

## Test plan
- Reset held 2 cycles → out_valid=0, out_data=0, in_ready=0; in_ready=1 on the cycle after release.
- Single word 0xDDCCBBAA, out_ready=1 → DD, CC, BB, AA on 4 consecutive cycles, then out_valid=0; out_last high only on AA when WDC_LAST_EN is defined.
- Back-to-back 0xFFFFFFFF, 0xDDDDDDDD, 0x00000003 with in_valid held → FF×4, DD×4, 00, 00, 00, 03 with no gaps; in_ready drops while hold_full.
- out_ready low for 3 cycles on slice 2 of 0x11223344 → out_data stays 0x22; stream resumes 22, 33, 44 with no loss.
- MSB_FIRST=0, word 0x11223344 → 44, 33, 22, 11.
- Reset pulse after 2 slices of 0xAABBCCDD with a second word held → out_valid=0 next cycle, no stale slices after reset.
